serial_rx: RTL and testbench

- 8N1 UART receiver that consumes the serial line produced by our `serial` transmitter, or by an external host.
- Oversamples the line at 16x baud and recovers each byte with 3-sample majority voting at bit centre.
- Presents the byte on a parallel bus with a single-cycle valid strobe.
- Flags stop-bit framing errors and line breaks.

---
 rtl/serial_rx_if.sv | 26 ++
 rtl/serial_rx.sv | 112 +++++++++++
 tb/tb_serial_rx.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_rx_if.sv
// Parallel-side bus of the UART receiver plus the serial line it listens to.
// master: the receiver (drives the byte bus, reads rx).
// slave:  the consumer / line driver (reads the byte bus, drives rx).
interface serial_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    modport master (
        input  rx,
        output data,
        output valid,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        input  data,
        input  valid,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/serial_rx.sv
// 8N1 UART receiver: 16x oversampling, 3-sample majority vote at bit centre,
// single-cycle valid / frame_err strobes, BREAK hold until the line returns high.
module serial_rx #(
    parameter int unsigned CLK_FREQ      = 50_000_000,
    parameter int unsigned BAUD          = 9600,
    parameter int unsigned CLK_MUL       = CLK_FREQ / (BAUD * 16),
    parameter int unsigned CLK_MUL_WIDTH = $clog2(CLK_MUL + 1)
) (
    input  logic        clk,
    input  logic        rst,
    serial_rx_if.master bus
);
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e                   state_q, state_d;
    logic [1:0]               sync_q;
    logic                     rx_s;
    logic [CLK_MUL_WIDTH-1:0] div_q;
    logic                     tick;
    logic [3:0]               os_q;
    logic [2:0]               bc_q;
    logic [1:0]               samp_q;   // votes from os=7 and os=8
    logic [7:0]               shift_q;
    logic [7:0]               data_q;
    logic                     valid_q;
    logic                     frame_err_q;
    logic                     maj;
    logic                     decide;
    logic                     busy;
    logic                     load_data;
    logic                     set_ferr;

    // Two-flop synchronizer; idles high so reset does not look like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], bus.rx};
    end

    assign rx_s = sync_q[1];

    // Free-running oversample divider, one tick every CLK_MUL clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       div_q <= '0;
        else if (tick) div_q <= '0;
        else           div_q <= div_q + CLK_MUL_WIDTH'(1);
    end

    assign tick   = (div_q == CLK_MUL_WIDTH'(CLK_MUL - 1));
    assign decide = tick && (os_q == 4'd9);
    // Third vote is rx_s itself on the os=9 tick.
    assign maj    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // FSM next-state logic; every transition is qualified by an oversample tick.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (tick && !rx_s) state_d = StStart;
            StStart: if (decide) state_d = maj ? StIdle : StData;
            StData:  if (decide && (bc_q == 3'd7)) state_d = StStop;
            StStop:  if (decide) state_d = maj ? StIdle : StBreak;
            StBreak: if (tick && rx_s) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: busy level and the stop-bit verdict.
    always_comb begin
        busy      = (state_q != StIdle);
        load_data = (state_q == StStop) && decide && maj;
        set_ferr  = (state_q == StStop) && decide && !maj;
    end

    // Datapath: oversample/bit counters, vote capture, shift register, strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            os_q        <= '0;
            bc_q        <= '0;
            samp_q      <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            valid_q     <= load_data;
            frame_err_q <= set_ferr;
            if (load_data) data_q <= shift_q;
            if (tick) begin
                // Holding os at 0 in idle makes the IDLE->START transition start at 0.
                if (state_q == StIdle) os_q <= '0;
                else                   os_q <= os_q + 4'd1;
                if (os_q == 4'd7) samp_q[0] <= rx_s;
                if (os_q == 4'd8) samp_q[1] <= rx_s;
            end
            if ((state_q == StStart) && decide) bc_q <= '0;
            if ((state_q == StData) && decide) begin
                shift_q[bc_q] <= maj;
                bc_q          <= bc_q + 3'd1;
            end
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy;
endmodule

// File: tb/tb_serial_rx.sv
// Bench for serial_rx: directed scenarios plus randomized frames with
// single-clock glitches, checked against the list of bytes put on the line.
module tb_serial_rx;
    localparam int unsigned CLK_FREQ = 1_600_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int          BIT_CLKS = 16;
    localparam int          N_RAND   = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;

    serial_rx_if bus ();

    serial_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe log, sampled on the falling edge.
    logic [7:0] vdata[$];
    int         vtime[$];
    logic       vbusy[$];
    int         ferr_cnt = 0;
    int         dual_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.valid) begin
                vdata.push_back(bus.data);
                vtime.push_back(cyc);
                vbusy.push_back(bus.busy);
            end
            if (bus.frame_err) ferr_cnt++;
            if (bus.valid && bus.frame_err) dual_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v);
        @(posedge clk);
        #1 bus.rx = v;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1);
    endtask

    // Frame of 10 bit-times: start, 8 data LSB first, stop. Optionally one
    // clock inverted at glitch_at, optionally truncated to ncyc clocks.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch_at,
                              input int ncyc);
        logic [9:0] bits;
        logic       v;
        bits = {stop, b, 1'b0};
        for (int c = 0; c < ncyc; c++) begin
            v = bits[c / BIT_CLKS];
            if (c == glitch_at) v = ~v;
            drive(v);
        end
    endtask

    int         n0;
    int         f0;
    int         diff;
    logic       seen;
    logic       dropped;
    logic [7:0] last_good;
    logic [7:0] b;
    logic [7:0] exp_q[$];
    int         gap;
    int         gl;

    initial begin
        bus.rx    = 1'b1;
        last_good = 8'h00;
        repeat (5) @(posedge clk);
        #1;
        check("rst_data", 32'(bus.data), 32'h00);
        check("rst_valid", 32'(bus.valid), 32'h0);
        check("rst_ferr", 32'(bus.frame_err), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        rst = 1'b0;

        // Quiet line after reset.
        n0 = vdata.size(); f0 = ferr_cnt; seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (bus.busy || bus.valid || bus.frame_err) seen = 1'b1;
        end
        check("idle_data", 32'(bus.data), 32'h00);
        check("idle_activity", 32'(seen), 32'h0);
        check("idle_strobes", 32'(vdata.size() - n0 + ferr_cnt - f0), 32'h0);

        // Single frames.
        n0 = vdata.size(); f0 = ferr_cnt;
        send_frame(8'h55, 1'b1, -1, 160); idle(20);
        check("f55_count", 32'(vdata.size() - n0), 32'd1);
        check("f55_data", 32'(vdata[n0]), 32'h55);
        send_frame(8'hA3, 1'b1, -1, 160); idle(20);
        check("fa3_count", 32'(vdata.size() - n0), 32'd2);
        check("fa3_data", 32'(vdata[n0+1]), 32'hA3);
        check("single_ferr", 32'(ferr_cnt - f0), 32'd0);

        // Back-to-back frames, no idle gap.
        n0 = vdata.size(); f0 = ferr_cnt;
        send_frame(8'h00, 1'b1, -1, 160);
        send_frame(8'hFF, 1'b1, -1, 160);
        send_frame(8'h3C, 1'b1, -1, 160);
        idle(20);
        last_good = 8'h3C;
        check("b2b_count", 32'(vdata.size() - n0), 32'd3);
        check("b2b_d0", 32'(vdata[n0]), 32'h00);
        check("b2b_d1", 32'(vdata[n0+1]), 32'hFF);
        check("b2b_d2", 32'(vdata[n0+2]), 32'h3C);
        for (int i = 1; i < 3; i++) begin
            diff = vtime[n0+i] - vtime[n0+i-1];
            check("b2b_spacing", 32'(diff >= 159 && diff <= 161), 32'd1);
        end
        check("b2b_ferr", 32'(ferr_cnt - f0), 32'd0);

        // Short low glitch on an idle line: false start rejected.
        n0 = vdata.size(); f0 = ferr_cnt;
        repeat (4) drive(1'b0);
        drive(1'b1);
        seen = 1'b0; dropped = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.busy) seen = 1'b1;
            else if (seen) dropped = 1'b1;
        end
        idle(10);
        check("glitch_busy_rose", 32'(seen), 32'd1);
        check("glitch_busy_fell", 32'(dropped), 32'd1);
        check("glitch_strobes", 32'(vdata.size() - n0 + ferr_cnt - f0), 32'd0);

        // Framing error followed by a break, then a good frame.
        n0 = vdata.size(); f0 = ferr_cnt;
        send_frame(8'h81, 1'b0, -1, 160);
        repeat (40) drive(1'b0);
        @(negedge clk);
        check("brk_busy", 32'(bus.busy), 32'd1);
        check("brk_ferr", 32'(ferr_cnt - f0), 32'd1);
        check("brk_no_valid", 32'(vdata.size() - n0), 32'd0);
        check("brk_data_kept", 32'(bus.data), 32'(last_good));
        drive(1'b1);
        dropped = 1'b0;
        for (int i = 0; i < 10 && !dropped; i++) begin
            @(negedge clk);
            if (!bus.busy) dropped = 1'b1;
        end
        check("brk_exit", 32'(dropped), 32'd1);
        idle(10);
        send_frame(8'h42, 1'b1, -1, 160); idle(20);
        last_good = 8'h42;
        check("brk_next_count", 32'(vdata.size() - n0), 32'd1);
        check("brk_next_data", 32'(vdata[n0]), 32'h42);
        check("brk_ferr_total", 32'(ferr_cnt - f0), 32'd1);

        // Reset in the middle of bit 4.
        n0 = vdata.size(); f0 = ferr_cnt;
        send_frame(8'hC7, 1'b1, -1, 5 * BIT_CLKS + 5);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_data", 32'(bus.data), 32'h00);
        bus.rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(20);
        check("midrst_no_strobe", 32'(vdata.size() - n0 + ferr_cnt - f0), 32'd0);
        send_frame(8'h19, 1'b1, -1, 160); idle(20);
        check("midrst_next_count", 32'(vdata.size() - n0), 32'd1);
        check("midrst_next_data", 32'(vdata[n0]), 32'h19);

        // One-clock glitch on the os=8 sample of bit 2.
        n0 = vdata.size();
        send_frame(8'h5A, 1'b1, 3 * BIT_CLKS + 9, 160); idle(20);
        check("vote_count", 32'(vdata.size() - n0), 32'd1);
        check("vote_data", 32'(vdata[n0]), 32'h5A);

        // Random bytes, random gaps, random single-clock glitches inside the frame.
        n0 = vdata.size(); f0 = ferr_cnt;
        for (int i = 0; i < N_RAND; i++) begin
            b   = 8'($urandom);
            gap = int'($urandom_range(0, 24));
            gl  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 150)) : -1;
            exp_q.push_back(b);
            send_frame(b, 1'b1, gl, 160);
            idle(gap);
        end
        idle(20);
        check("rand_count", 32'(vdata.size() - n0), 32'(N_RAND));
        for (int i = 0; i < N_RAND && (n0 + i) < vdata.size(); i++) begin
            check("rand_data", 32'(vdata[n0+i]), 32'(exp_q[i]));
        end
        check("rand_ferr", 32'(ferr_cnt - f0), 32'd0);

        // Strobe properties over the whole run.
        for (int i = 0; i < vbusy.size(); i++) begin
            check("busy_low_at_valid", 32'(vbusy[i]), 32'd0);
        end
        check("valid_ferr_overlap", 32'(dual_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
